// File: rtl/fp.sv
// Fixed-point word format shared by the dendrite datapath and its configuration chain.
package fp;
   localparam int WORD_LENGTH = 16;

   typedef logic [WORD_LENGTH-1:0] fpType;

   typedef enum logic [1:0] {
      CFG_E_L     = 2'd0,
      CFG_TAU_MEM = 2'd1,
      CFG_G_INT   = 2'd2
   } cfg_param_e;
endpackage

// File: rtl/config_if.sv
// Head-of-chain configuration link: a slow data_clk and the word it qualifies.
interface config_if;
   import fp::*;

   logic  data_clk;
   fpType data_in;

   modport master (output data_clk, output data_in);
   modport slave  (input data_clk, input data_in);
endinterface

// File: rtl/dendrite_cfg_loader_buffer.sv
// Parameter staging register file: one write port, one asynchronous read port, cleared by reset.
module cfg_word_buffer
   import fp::*;
#(
   parameter int DEPTH = 12,
   parameter int AW    = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [WORD_LENGTH-1:0] wdata,
   input  logic [AW-1:0]          raddr,
   output logic [WORD_LENGTH-1:0] rdata
);

   logic [WORD_LENGTH-1:0] mem [DEPTH];

   // storage update and synchronous clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {WORD_LENGTH{1'b0}};
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dendrite_cfg_loader.sv
// Buffers per-compartment parameters and shifts them tail-first onto the dendrite chain.
// Optional build macro DENDRITE_CFG_FREEZE_EN adds the freeze output.
module dendrite_cfg_loader
   import fp::*;
#(
   parameter int NUM_COMP       = 4,
   parameter int WORDS_PER_COMP = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [$clog2(NUM_COMP)-1:0] wr_comp,
   input  logic [1:0]                  wr_param,
   input  logic [WORD_LENGTH-1:0]      wr_data,
   output logic                        wr_err,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
`ifdef DENDRITE_CFG_FREEZE_EN
   output logic                        freeze,
`endif
   config_if.master                    cfg_out
);

   localparam int T  = NUM_COMP * WORDS_PER_COMP;
   localparam int IW = $clog2(T);
   localparam logic [IW-1:0] LAST_IDX = IW'(T - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]             state_r;
   logic [1:0]             state_nx;
   logic [IW-1:0]          ptr_r;
   logic                   wr_ready_r;
   logic                   busy_r;
   logic                   done_r;
   logic                   wr_err_r;
   logic                   data_clk_r;
   logic [WORD_LENGTH-1:0] data_in_r;
   logic [WORD_LENGTH-1:0] rd_word;
   logic [IW-1:0]          wr_idx;
   logic                   wr_fire;
   logic                   wr_legal;
   logic                   load_go;
   logic                   busy_nx;

   // wr_ready_r is high exactly when the FSM is idle and no done cycle is pending
   assign wr_fire  = wr_valid && wr_ready_r;
   assign load_go  = start && wr_ready_r;
   assign wr_legal = (32'(wr_comp) < 32'(NUM_COMP)) && (32'(wr_param) < 32'(WORDS_PER_COMP));
   assign wr_idx   = IW'(int'(wr_comp) * WORDS_PER_COMP + int'(wr_param));
   assign busy_nx  = (state_nx != ST_IDLE) || (state_r == ST_DONE);

   cfg_word_buffer #(
      .DEPTH (T),
      .AW    (IW)
   ) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_fire && wr_legal),
      .waddr   (wr_idx),
      .wdata   (wr_data),
      .raddr   (ptr_r),
      .rdata   (rd_word)
   );

   // next-state decode for the shift sequencer
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_go) state_nx = ST_LO;
            else         state_nx = ST_IDLE;
         end
         ST_LO:   state_nx = ST_HI;
         ST_HI: begin
            if (ptr_r == {IW{1'b0}}) state_nx = ST_DONE;
            else                     state_nx = ST_LO;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // state, pointer and registered outputs; outputs trail the state by one cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         ptr_r      <= {IW{1'b0}};
         wr_ready_r <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         wr_err_r   <= 1'b0;
         data_clk_r <= 1'b0;
         data_in_r  <= {WORD_LENGTH{1'b0}};
      end else begin
         state_r <= state_nx;
         if ((state_r == ST_IDLE) && load_go) begin
            ptr_r <= LAST_IDX;
         end else if ((state_r == ST_HI) && (ptr_r != {IW{1'b0}})) begin
            ptr_r <= ptr_r - IW'(1);
         end
         wr_ready_r <= !busy_nx;
         busy_r     <= busy_nx;
         done_r     <= (state_r == ST_DONE);
         wr_err_r   <= wr_fire && !wr_legal;
         data_clk_r <= (state_r == ST_HI);
         if (state_r == ST_LO) begin
            data_in_r <= rd_word;
         end
      end
   end

`ifdef DENDRITE_CFG_FREEZE_EN
   logic freeze_r;

   // holds compartment integration off from the cycle after start through done
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         freeze_r <= 1'b0;
      end else begin
         freeze_r <= busy_nx;
      end
   end

   assign freeze = freeze_r;
`endif

   assign wr_ready         = wr_ready_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign wr_err           = wr_err_r;
   assign cfg_out.data_clk = data_clk_r;
   assign cfg_out.data_in  = data_in_r;

endmodule

// File: tb/tb_dendrite_cfg_loader.sv
// Directed bench for dendrite_cfg_loader driving a behavioural 4x3-word dendrite shift chain.
module tb_dendrite_cfg_loader;
   import fp::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [1:0]  wr_comp = 2'd0;
   logic [1:0]  wr_param = 2'd0;
   logic [15:0] wr_data = 16'h0000;
   logic        wr_err;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
`ifdef DENDRITE_CFG_FREEZE_EN
   logic        freeze;
`endif

   int tests = 0;
   int fails = 0;

   config_if cfg_bus ();

   dendrite_cfg_loader dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_comp  (wr_comp),
      .wr_param (wr_param),
      .wr_data  (wr_data),
      .wr_err   (wr_err),
      .start    (start),
      .busy     (busy),
      .done     (done),
`ifdef DENDRITE_CFG_FREEZE_EN
      .freeze   (freeze),
`endif
      .cfg_out  (cfg_bus)
   );

   always #5 clk = ~clk;

   // four chained compartments, 3 words each; position 0 is comp0 E_l at the chain head
   logic [15:0] chain [12];
   int          edge_cnt = 0;
   logic [15:0] exp_buf [12];

   always @(posedge cfg_bus.data_clk) begin
      for (int i = 11; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= cfg_bus.data_in;
      edge_cnt <= edge_cnt + 1;
   end

   task automatic do_write(input logic [1:0] c, input logic [1:0] p, input logic [15:0] d);
      wr_valid = 1'b1; wr_comp = c; wr_param = p; wr_data = d;
      @(negedge clk);
      wr_valid = 1'b0;
      exp_buf[int'(c)*3 + int'(p)] = d;
   endtask

   // issues start at a negedge and observes a fixed 30-cycle window
   task automatic run_load(input int restart_at, input int busywr_at,
                           output int lat, output int edges, output int busy_cyc,
                           output int done_cnt, output int frz_cyc);
      int e0;
      lat = -1; busy_cyc = 0; done_cnt = 0; frz_cyc = 0;
      e0 = edge_cnt;
      start = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 1) begin start = 1'b0; wr_valid = 1'b0; end
         if (n == restart_at) start = 1'b1;
         if (n == restart_at + 1) start = 1'b0;
         if (n == busywr_at) begin
            wr_valid = 1'b1; wr_comp = 2'd0; wr_param = 2'd1; wr_data = 16'hBEEF;
         end
         if (n == busywr_at + 1) wr_valid = 1'b0;
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            if (lat < 0) lat = n;
         end
`ifdef DENDRITE_CFG_FREEZE_EN
         if (freeze) frz_cyc++;
`endif
      end
      edges = edge_cnt - e0;
   endtask

   task automatic check_chain(input string name);
      for (int k = 0; k < 12; k++) begin
         tests++;
         if (chain[k] !== exp_buf[k]) begin
            fails++;
            $display("FAIL %s word %0d: got %h expected %h", name, k, chain[k], exp_buf[k]);
         end
      end
   endtask

   task automatic check_load(input string name, input int lat, input int edges,
                             input int busy_cyc, input int done_cnt, input int frz_cyc);
      tests++;
      if (lat !== 26) begin fails++; $display("FAIL %s latency: got %0d expected 26", name, lat); end
      tests++;
      if (edges !== 12) begin fails++; $display("FAIL %s data_clk edges: got %0d expected 12", name, edges); end
      tests++;
      if (busy_cyc !== 26) begin fails++; $display("FAIL %s busy cycles: got %0d expected 26", name, busy_cyc); end
      tests++;
      if (done_cnt !== 1) begin fails++; $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt); end
`ifdef DENDRITE_CFG_FREEZE_EN
      tests++;
      if (frz_cyc !== 26) begin fails++; $display("FAIL %s freeze cycles: got %0d expected 26", name, frz_cyc); end
`else
      if (frz_cyc != 0) $display("note: freeze counted without feature");
`endif
   endtask

   task automatic check_idle_outputs(input string name);
      tests++;
      if ({wr_ready, busy, done, wr_err, cfg_bus.data_clk} !== 5'b10000 || cfg_bus.data_in !== 16'h0000) begin
         fails++;
         $display("FAIL %s: got ready=%b busy=%b done=%b err=%b dclk=%b din=%h expected 1 0 0 0 0 0000",
                  name, wr_ready, busy, done, wr_err, cfg_bus.data_clk, cfg_bus.data_in);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset values");
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("post-reset idle");
      for (int k = 0; k < 12; k++) exp_buf[k] = 16'h0000;
   endtask

   task automatic test_full_load();
      int lat, edges, bc, dc, fc;
      for (int c = 0; c < 4; c++)
         for (int p = 0; p < 3; p++)
            do_write(2'(c), 2'(p), 16'(16'h0100 * c + p));
      run_load(0, 0, lat, edges, bc, dc, fc);
      check_load("full load", lat, edges, bc, dc, fc);
      tests++;
      if ({chain[6], chain[7], chain[8]} !== {16'h0200, 16'h0201, 16'h0202}) begin
         fails++;
         $display("FAIL comp2 words: got %h %h %h expected 0200 0201 0202", chain[6], chain[7], chain[8]);
      end
      check_chain("full load");
   endtask

   task automatic test_illegal_write();
      int lat, edges, bc, dc, fc;
      wr_valid = 1'b1; wr_comp = 2'd1; wr_param = 2'd3; wr_data = 16'hDEAD;
      @(negedge clk);
      wr_valid = 1'b0;
      tests++;
      if (wr_err !== 1'b1) begin fails++; $display("FAIL wr_err pulse: got %b expected 1", wr_err); end
      @(negedge clk);
      tests++;
      if (wr_err !== 1'b0) begin fails++; $display("FAIL wr_err width: got %b expected 0", wr_err); end
      run_load(0, 0, lat, edges, bc, dc, fc);
      check_chain("after illegal write");
   endtask

   task automatic test_start_while_busy();
      int lat, edges, bc, dc, fc;
      run_load(5, 7, lat, edges, bc, dc, fc);
      check_load("restart ignored", lat, edges, bc, dc, fc);
      check_chain("write during busy dropped");
   endtask

   task automatic test_write_with_start();
      int lat, edges, bc, dc, fc;
      wr_valid = 1'b1; wr_comp = 2'd0; wr_param = 2'd0; wr_data = 16'h7FFF;
      exp_buf[0] = 16'h7FFF;
      run_load(0, 0, lat, edges, bc, dc, fc);
      check_load("write with start", lat, edges, bc, dc, fc);
      tests++;
      if (chain[0] !== 16'h7FFF) begin fails++; $display("FAIL comp0 E_l: got %h expected 7fff", chain[0]); end
   endtask

   task automatic test_reset_mid_load();
      int lat, edges, bc, dc, fc, dn;
      dn = 0;
      start = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (done) dn++;
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_idle_outputs("reset mid-load");
      repeat (30) begin
         @(negedge clk);
         if (done) dn++;
      end
      tests++;
      if (dn !== 0) begin fails++; $display("FAIL aborted load done pulses: got %0d expected 0", dn); end
      for (int k = 0; k < 12; k++) exp_buf[k] = 16'h0000;
      run_load(0, 0, lat, edges, bc, dc, fc);
      check_load("load of cleared buffer", lat, edges, bc, dc, fc);
      check_chain("cleared buffer");
      for (int c = 0; c < 4; c++)
         for (int p = 0; p < 3; p++)
            do_write(2'(c), 2'(p), 16'(16'hA000 + 16'h0010 * c + p));
      run_load(0, 0, lat, edges, bc, dc, fc);
      check_load("reload after reset", lat, edges, bc, dc, fc);
      check_chain("reload after reset");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_full_load();
      test_illegal_write();
      test_start_while_busy();
      test_write_with_start();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
